// File: rtl/bus_controller_pkg.sv
// ---------------------------------------------------------------------------
// bus_controller_pkg
//   Shared definitions for the cache-to-memory bus controller: request
//   layout, command encodings, invalidate reset value, FSM state encoding,
//   and the invalidate-address update helper.
//
//   Optional feature macro: BUS_TIMEOUT_EN (used by bus_controller only).
// ---------------------------------------------------------------------------
package bus_controller_pkg;

  localparam int REQ_W  = 25;  // {r/w, data[7:0], addr[15:0]}
  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 16;

  // Address bits above this index identify a line; bit 0 is the offset.
  localparam int LINE_LSB = 1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [ADDR_W-1:0] INV_RESET = 16'hFFFF;

  typedef struct packed {
    logic              cmd;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } mem_req_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_RESPOND  = 2'd3
  } state_t;

  // Caches only react when their invalidate input changes. If the slice
  // already names the written line, flip the offset bit so a repeat write
  // to the same line still produces a visible change.
  function automatic logic [ADDR_W-1:0] next_invalidate(
    input logic [ADDR_W-1:0] current,
    input logic [ADDR_W-1:0] addr
  );
    if (current[ADDR_W-1:LINE_LSB] == addr[ADDR_W-1:LINE_LSB])
      return {addr[ADDR_W-1:LINE_LSB], ~current[0]};
    return addr;
  endfunction

endpackage

// File: rtl/bus_controller_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first set bit of `eligible` at or
//   after `rr_ptr`, wrapping around.
//
//   Ports:
//     eligible    in  N    request vector already masked by holdoff
//     rr_ptr      in  IW   index with highest priority this cycle
//     grant_valid out 1    at least one eligible bit
//     grant_index out IW   chosen index (0 when grant_valid is low)
// ---------------------------------------------------------------------------
module rr_arbiter
  import bus_controller_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_index
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest eligible index
  // after rr_ptr is the last assignment and therefore wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N;
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_controller.sv
// ---------------------------------------------------------------------------
// bus_controller
//   Arbitrates round-robin among per-core cache miss/write-through requests,
//   forwards one at a time to main memory, returns the line to the requester
//   and, on writes, broadcasts the written address to every other cache's
//   invalidate port.
//
//   Optional feature macro: BUS_TIMEOUT_EN
//     defined   : WAIT_MEM watchdog; after TIMEOUT_CYCLES cycles without a
//                 memory response the requester gets line 16'h0000, no
//                 invalidate is issued and bus_error is set (sticky).
//     undefined : WAIT_MEM waits indefinitely, bus_error tied low.
//
//   Ports:
//     clock                 in   1             posedge clock
//     reset                 in   1             async, active low
//     cache_request         in   25*N          slice i = cache i request
//     cache_request_ready   in   N             request level per cache
//     cache_response        out  16            returned line (shared)
//     cache_response_ready  out  N             one-hot, one-cycle pulse
//     invalidate_address    out  16*N          slice j goes to cache j
//     mem_request           out  25            forwarded request
//     mem_request_valid     out  1             request handshake valid
//     mem_request_accept    in   1             request handshake accept
//     mem_response          in   16            memory line
//     mem_response_valid    in   1             one-cycle response pulse
//     bus_error             out  1             sticky timeout flag
// ---------------------------------------------------------------------------
// state       | meaning
// ST_IDLE     | pick next eligible cache, latch its request
// ST_ISSUE    | mem_request_valid high until memory accepts
// ST_WAIT_MEM | waiting for mem_response_valid (or watchdog)
// ST_RESPOND  | response pulse cycle; advance rr_ptr, arm holdoff
// ---------------------------------------------------------------------------
module bus_controller
  import bus_controller_pkg::*;
#(
  parameter int NUM_CACHES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REQ_W*NUM_CACHES-1:0]  cache_request,
  input  logic [NUM_CACHES-1:0]        cache_request_ready,
  output logic [LINE_W-1:0]            cache_response,
  output logic [NUM_CACHES-1:0]        cache_response_ready,
  output logic [ADDR_W*NUM_CACHES-1:0] invalidate_address,
  output logic [REQ_W-1:0]             mem_request,
  output logic                         mem_request_valid,
  input  logic                         mem_request_accept,
  input  logic [LINE_W-1:0]            mem_response,
  input  logic                         mem_response_valid,
  output logic                         bus_error
);

  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  state_t                state;
  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         grant_q;
  logic [NUM_CACHES-1:0] holdoff;
  logic [NUM_CACHES-1:0] eligible;
  logic [NUM_CACHES-1:0] grant_onehot;
  logic                  grant_valid;
  logic [IW-1:0]         grant_index;
  mem_req_t              req_q;

`ifdef BUS_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TIMER_W-1:0] timer;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign bus_error = 1'b0;
`endif

  // A cache drops its ready level only after it has seen its response, so
  // the just-served port is masked for one IDLE cycle.
  assign eligible     = cache_request_ready & ~holdoff;
  assign grant_onehot = NUM_CACHES'(1) << grant_q;
  assign req_q        = mem_req_t'(mem_request);

  rr_arbiter #(
    .N  (NUM_CACHES),
    .IW (IW)
  ) u_arbiter (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_index (grant_index)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= ST_IDLE;
      rr_ptr               <= '0;
      grant_q              <= '0;
      holdoff              <= '0;
      mem_request          <= '0;
      mem_request_valid    <= 1'b0;
      cache_response       <= '0;
      cache_response_ready <= '0;
      invalidate_address   <= {NUM_CACHES{INV_RESET}};
`ifdef BUS_TIMEOUT_EN
      timer                <= '0;
      bus_error            <= 1'b0;
`endif
    end else begin
      cache_response_ready <= '0;
      case (state)
        ST_IDLE: begin
          holdoff <= '0;
          if (grant_valid) begin
            grant_q           <= grant_index;
            mem_request       <= cache_request[int'(grant_index)*REQ_W +: REQ_W];
            mem_request_valid <= 1'b1;
            state             <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (mem_request_accept) begin
            mem_request_valid <= 1'b0;
            state             <= ST_WAIT_MEM;
`ifdef BUS_TIMEOUT_EN
            timer             <= TIMER_W'(TIMEOUT_CYCLES - 1);
`endif
          end
        end

        ST_WAIT_MEM: begin
          if (mem_response_valid) begin
            cache_response       <= mem_response;
            cache_response_ready <= grant_onehot;
            state                <= ST_RESPOND;
            if (req_q.cmd == CMD_WRITE) begin
              for (int j = 0; j < NUM_CACHES; j++) begin
                if (j != int'(grant_q))
                  invalidate_address[j*ADDR_W +: ADDR_W] <=
                    next_invalidate(invalidate_address[j*ADDR_W +: ADDR_W], req_q.addr);
              end
            end
          end
`ifdef BUS_TIMEOUT_EN
          else if (timer == '0) begin
            cache_response       <= '0;
            cache_response_ready <= grant_onehot;
            bus_error            <= 1'b1;
            state                <= ST_RESPOND;
          end else begin
            timer <= timer - 1'b1;
          end
`endif
        end

        ST_RESPOND: begin
          rr_ptr  <= (grant_q == IW'(NUM_CACHES - 1)) ? '0 : grant_q + 1'b1;
          holdoff <= grant_onehot;
          state   <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
